// File: rtl/wave_meter.sv
// wave_meter: gated waveform measurement block.
//   A hysteresis comparator turns the sample stream into a level. Over a
//   window of GATE_CYC clocks the block counts rising level transitions
//   (frequency), high cycles (duty) and, optionally, sample extremes.
//   Duty percent is then produced by a serial repeated-subtraction divider.
//
// Parameters:
//   GATE_CYC     measurement window length in clk cycles
//   HYST         comparator hysteresis in LSBs
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sample       12-bit unsigned waveform sample
//   sample_valid sample qualifier
//   start        single-cycle measurement request (honoured in IDLE only)
//   cont         back-to-back measurements while high
//   freq_out     rising crossings in the last window
//   duty_out     percent of window cycles with the level high (0-100)
//   vmax_out     largest sample in the last window (0 without min/max)
//   vmin_out     smallest sample in the last window (0 without min/max)
//   meas_valid   one-cycle pulse when all results update
//   busy         FSM not idle
//   ovf          edge counter saturated in the last window
// Configuration:
//   WAVE_METER_MINMAX_EN  enables min/max tracking and an adaptive threshold
//                         of (max+min)>>1 taken from the previous window.

module wave_meter #(
  parameter int unsigned GATE_CYC = 100000000,
  parameter int unsigned HYST     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  input  logic        start,
  input  logic        cont,
  output logic [19:0] freq_out,
  output logic [6:0]  duty_out,
  output logic [11:0] vmax_out,
  output logic [11:0] vmin_out,
  output logic        meas_valid,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned CW      = $clog2(GATE_CYC + 1);
  localparam int unsigned DIV_RAW = GATE_CYC / 100;
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam logic [11:0] HYST12  = (HYST > 4095) ? 12'hFFF : 12'(HYST);
  localparam logic [11:0] THR_RST = 12'h800;
  localparam logic [19:0] EDGE_MAX = 20'hFFFFF;
  localparam logic [6:0]  DUTY_MAX = 7'd100;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GATE   = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [11:0]   thr;
  logic          level;
  logic          level_nx;
  logic [11:0]   hi_thr;
  logic [11:0]   lo_thr;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] high_cnt_nx;
  logic [CW-1:0] rem;
  logic [6:0]    quot;
  logic [19:0]   edge_cnt;
  logic          ovf_win;
  logic          gate_entry;
  logic          rise_c;
  logic          div_done_c;

  // Clamped comparator thresholds around thr.
  always_comb begin
    hi_thr = 12'hFFF;
    lo_thr = 12'h000;
    if (32'(thr) + HYST <= 32'd4095) hi_thr = thr + HYST12;
    if (HYST <= 32'(thr))            lo_thr = thr - HYST12;
  end

  // Hysteresis comparator; level only moves on a qualified sample.
  always_comb begin
    level_nx = level;
    if (sample_valid) begin
      if (sample >= hi_thr)     level_nx = 1'b1;
      else if (sample < lo_thr) level_nx = 1'b0;
    end
  end

  // Window event detection uses the level including this cycle's sample,
  // so a sample on the last gate cycle still lands in the current window.
  always_comb begin
    rise_c      = (state == S_GATE) && !level && level_nx;
    high_cnt_nx = high_cnt + CW'((state == S_GATE) && level_nx);
    div_done_c  = (rem < CW'(DIV)) || (quot == DUTY_MAX);
    gate_entry  = (state_nx == S_GATE) && (state != S_GATE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start || cont) state_nx = S_GATE;
      S_GATE:   if (win_cnt == CW'(GATE_CYC - 1)) state_nx = S_DIVIDE;
      S_DIVIDE: if (div_done_c) state_nx = S_DONE;
      S_DONE:   state_nx = cont ? S_GATE : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Window counters, divider and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= 1'b0;
      win_cnt    <= '0;
      high_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_win    <= 1'b0;
      rem        <= '0;
      quot       <= '0;
      freq_out   <= '0;
      duty_out   <= '0;
      ovf        <= 1'b0;
      meas_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      level      <= level_nx;
      meas_valid <= (state == S_DONE);
      busy       <= (state_nx != S_IDLE);
      if (gate_entry) begin
        win_cnt  <= '0;
        high_cnt <= '0;
        edge_cnt <= '0;
        ovf_win  <= 1'b0;
      end else if (state == S_GATE) begin
        win_cnt  <= win_cnt + CW'(1);
        high_cnt <= high_cnt_nx;
        if (rise_c) begin
          if (edge_cnt == EDGE_MAX) ovf_win  <= 1'b1;
          else                      edge_cnt <= edge_cnt + 20'd1;
        end
      end
      // Divider is seeded with the final high count on the last gate cycle.
      if (state == S_GATE && state_nx == S_DIVIDE) begin
        rem  <= high_cnt_nx;
        quot <= '0;
      end else if (state == S_DIVIDE && !div_done_c) begin
        rem  <= rem - CW'(DIV);
        quot <= quot + 7'd1;
      end
      if (state == S_DONE) begin
        freq_out <= edge_cnt;
        duty_out <= quot;
        ovf      <= ovf_win;
      end
    end
  end

`ifdef WAVE_METER_MINMAX_EN
  logic [11:0] win_max;
  logic [11:0] win_min;

  // Per-window extremes; threshold re-centres on them for the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_max  <= 12'h000;
      win_min  <= 12'hFFF;
      vmax_out <= 12'h000;
      vmin_out <= 12'h000;
      thr      <= THR_RST;
    end else begin
      if (gate_entry) begin
        win_max <= 12'h000;
        win_min <= 12'hFFF;
      end else if (state == S_GATE && sample_valid) begin
        if (sample > win_max) win_max <= sample;
        if (sample < win_min) win_min <= sample;
      end
      if (state == S_DONE) begin
        vmax_out <= win_max;
        vmin_out <= win_min;
        thr      <= 12'((13'(win_max) + 13'(win_min)) >> 1);
      end
    end
  end
`else
  assign vmax_out = 12'h000;
  assign vmin_out = 12'h000;
  assign thr      = THR_RST;
`endif

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter with GATE_CYC=1000, HYST=64.
// Waveform generator: phase ph runs 0..period-1, sample is lo for the first
// period-high_len phases and hi for the rest. Phase 0 is the sample driven on
// the negedge where start/cont is raised, so gate cycle k sees phase k.
module tb_wave_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample = 12'h000;
  logic        sample_valid = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [19:0] freq_out;
  logic [6:0]  duty_out;
  logic [11:0] vmax_out;
  logic [11:0] vmin_out;
  logic        meas_valid;
  logic        busy;
  logic        ovf;

  int passed = 0;
  int total  = 0;
  int period = 100;
  int high_len = 50;
  int ph = 0;
  logic [11:0] lo_v = 12'h000;
  logic [11:0] hi_v = 12'hFFF;

  always #5 clk = ~clk;

  wave_meter #(.GATE_CYC(1000), .HYST(64)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .start(start), .cont(cont), .freq_out(freq_out), .duty_out(duty_out),
    .vmax_out(vmax_out), .vmin_out(vmin_out), .meas_valid(meas_valid),
    .busy(busy), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: outputs are observed at the negedge, then the next sample is driven.
  task automatic step();
    @(negedge clk);
    ph = (ph + 1 >= period) ? 0 : ph + 1;
    sample = (ph >= period - high_len) ? hi_v : lo_v;
  endtask

  task automatic set_wave(input int p, input int h, input logic [11:0] lo, input logic [11:0] hi);
    period = p; high_len = h; lo_v = lo; hi_v = hi; ph = p - 1;
  endtask

  // Request a measurement and wait for meas_valid; lat counts clocks from the
  // edge that captures the request, inclusive.
  task automatic run_meas(input bit use_cont, input int budget, output int lat, output bit seen);
    step();
    if (use_cont) cont = 1'b1; else start = 1'b1;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      start = 1'b0;
      lat++;
      if (meas_valid) seen = 1'b1;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    int n;

    // Reset state
    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_freq", 32'(freq_out), 0);
    check("rst_duty", 32'(duty_out), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_vmax", 32'(vmax_out), 0);
    check("rst_vmin", 32'(vmin_out), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // 50% square, period 100: 10 rises, 500 high cycles, 51 divide cycles
    set_wave(100, 50, 12'h000, 12'hFFF);
    run_meas(1'b0, 1200, lat, seen);
    check("sq50_seen", 32'(seen), 1);
    check("sq50_lat", 32'(lat), 1053);
    check("sq50_freq", 32'(freq_out), 10);
    check("sq50_duty", 32'(duty_out), 50);
    check("sq50_ovf", 32'(ovf), 0);
    step();
    check("sq50_pulse", 32'(meas_valid), 0);

    // 25% square: 250 high cycles, 26 divide cycles
    set_wave(100, 25, 12'h000, 12'hFFF);
    run_meas(1'b0, 1200, lat, seen);
    check("sq25_seen", 32'(seen), 1);
    check("sq25_lat", 32'(lat), 1028);
    check("sq25_freq", 32'(freq_out), 10);
    check("sq25_duty", 32'(duty_out), 25);
`ifdef WAVE_METER_MINMAX_EN
    check("sq25_vmax", 32'(vmax_out), 32'h0FFF);
    check("sq25_vmin", 32'(vmin_out), 0);
`else
    check("sq25_vmax", 32'(vmax_out), 0);
    check("sq25_vmin", 32'(vmin_out), 0);
`endif

    // Constant high: no edges, duty capped at 100 after 101 divide cycles
    set_wave(1, 1, 12'hFFF, 12'hFFF);
    run_meas(1'b0, 1300, lat, seen);
    check("const_seen", 32'(seen), 1);
    check("const_lat", 32'(lat), 1103);
    check("const_freq", 32'(freq_out), 0);
    check("const_duty", 32'(duty_out), 100);

    // Continuous mode, period 100 -> 50 after first result.
    // Window 2: first cycle still old wave (high), then 999 cycles of new wave.
    set_wave(100, 50, 12'h000, 12'hFFF);
    run_meas(1'b1, 1200, lat, seen);
    check("cont1_seen", 32'(seen), 1);
    check("cont1_freq", 32'(freq_out), 10);
    check("cont1_duty", 32'(duty_out), 50);
    set_wave(50, 25, 12'h000, 12'hFFF);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      step();
      n++;
      if (meas_valid) seen = 1'b1;
    end
    check("cont2_seen", 32'(seen), 1);
    check("cont2_gap", 32'(n), 1052);
    check("cont2_freq", 32'(freq_out), 20);
    check("cont2_duty", 32'(duty_out), 50);
    cont = 1'b0;
    n = 0;
    for (int i = 0; i < 2500 && busy; i++) begin
      step();
      n++;
    end
    check("cont_stop_busy", 32'(busy), 0);

    // Start during GATE is ignored: exactly one result
    set_wave(100, 50, 12'h000, 12'hFFF);
    step();
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 2500; i++) begin
      step();
      start = (i == 300);
      if (i == 300) check("ign_busy", 32'(busy), 1);
      if (meas_valid) n++;
    end
    start = 1'b0;
    check("ign_count", 32'(n), 1);
    check("ign_freq", 32'(freq_out), 10);

    // Reset at window cycle 500 aborts with no result
    step();
    start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      start = 1'b0;
    end
    rst_n = 1'b0;
    set_wave(2, 1, 12'h7F0, 12'h810);
    repeat (3) step();
    check("abort_busy", 32'(busy), 0);
    check("abort_freq", 32'(freq_out), 0);
    check("abort_duty", 32'(duty_out), 0);
    check("abort_valid", 32'(meas_valid), 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (meas_valid) n++;
    end
    check("abort_nopulse", 32'(n), 0);
    check("abort_idle", 32'(busy), 0);

    // Toggling inside hysteresis band: level stays low
    run_meas(1'b0, 1200, lat, seen);
    check("hyst_seen", 32'(seen), 1);
    check("hyst_lat", 32'(lat), 1003);
    check("hyst_freq", 32'(freq_out), 0);
    check("hyst_duty", 32'(duty_out), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
